li_expander: RTL and testbench

- Inverse of the immediate-extension path: takes a 32-bit constant plus a destination register and emits the shortest MIPS instruction sequence that loads it.
- The sequence uses only immediate forms the EXT unit can reproduce: addiu (sign-ext, EOp 00), ori (zero-ext, EOp 01), lui (EOp 10).
- Sits between the test-program generator / boot ROM loader and instruction memory.
- Streams 1 or 2 instruction words over a valid/ready interface.

---
 rtl/li_expander_pkg.sv | 27 ++
 rtl/li_expander_classify.sv | 22 ++
 rtl/li_expander.sv | 94 +++++++++
 tb/tb_li_expander.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/li_expander_pkg.sv
// Shared constants and types for the load-immediate expander.
// Optional feature macro used by li_expander: LI_EXPANDER_ZERO_DROP_EN.
package li_expander_pkg;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;

   localparam logic [1:0] EOP_SIGN = 2'b00;
   localparam logic [1:0] EOP_ZERO = 2'b01;
   localparam logic [1:0] EOP_LUI  = 2'b10;
   localparam logic [1:0] EOP_BR   = 2'b11;

   typedef enum logic [1:0] {IDLE, EMIT1, EMIT2} state_t;
   typedef enum logic [1:0] {FORM_ADDIU, FORM_ORI, FORM_LUI, FORM_PAIR} form_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [1:0]  eop;
      logic        last;
   } word_t;

   // I-type encoding: opcode, rs, rt, imm16
   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction
endpackage

// File: rtl/li_expander_classify.sv
// Picks the shortest immediate form able to reproduce a 32-bit constant.
module li_classify
   import li_expander_pkg::*;
#(
   parameter bit USE_ADDIU = 1'b1
) (
   input  logic [31:0] value,
   output form_t       form
);
   logic [15:0] hi, lo;

   assign hi = value[31:16];
   assign lo = value[15:0];

   // Priority order matters: 0 must resolve to addiu when that form is enabled.
   always_comb begin
      form = FORM_PAIR;
      if (USE_ADDIU && (hi == {16{lo[15]}})) form = FORM_ADDIU;
      else if (hi == 16'd0)                  form = FORM_ORI;
      else if (lo == 16'd0)                  form = FORM_LUI;
   end
endmodule

// File: rtl/li_expander.sv
// Expands a 32-bit constant into a 1- or 2-word MIPS load sequence.
// LI_EXPANDER_ZERO_DROP_EN: when defined, requests targeting r0 are swallowed.
module li_expander
   import li_expander_pkg::*;
#(
   parameter bit USE_ADDIU = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_value,
   input  logic [4:0]  in_rt,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [1:0]  out_eop,
   output logic        out_last
);
   state_t      state_q, state_d;
   word_t       word_q, word_d;
   logic [4:0]  rt_q, rt_d;
   logic [15:0] lo_q, lo_d;
   form_t       form;
   logic        take;

   li_classify #(.USE_ADDIU(USE_ADDIU)) u_classify (
      .value (in_value),
      .form  (form)
   );

`ifdef LI_EXPANDER_ZERO_DROP_EN
   assign take = in_valid && (in_rt != 5'd0);
`else
   assign take = in_valid;
`endif

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q != IDLE);
   assign out_instr = word_q.instr;
   assign out_eop   = word_q.eop;
   assign out_last  = word_q.last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         word_q  <= '0;
         rt_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         rt_q    <= rt_d;
         lo_q    <= lo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      rt_d    = rt_q;
      lo_d    = lo_q;
      case (state_q)
         IDLE: begin
            if (take) begin
               rt_d    = in_rt;
               lo_d    = in_value[15:0];
               state_d = EMIT1;
               case (form)
                  FORM_ADDIU: word_d = {enc_i(OP_ADDIU, 5'd0, in_rt, in_value[15:0]), EOP_SIGN, 1'b1};
                  FORM_ORI:   word_d = {enc_i(OP_ORI,   5'd0, in_rt, in_value[15:0]), EOP_ZERO, 1'b1};
                  FORM_LUI:   word_d = {enc_i(OP_LUI,   5'd0, in_rt, in_value[31:16]), EOP_LUI, 1'b1};
                  default:    word_d = {enc_i(OP_LUI,   5'd0, in_rt, in_value[31:16]), EOP_LUI, 1'b0};
               endcase
            end
         end
         EMIT1: begin
            if (out_ready) begin
               if (word_q.last) begin
                  state_d = IDLE;
               end else begin
                  // second half of the pair ORs the low half into the lui result
                  word_d  = {enc_i(OP_ORI, rt_q, rt_q, lo_q), EOP_ZERO, 1'b1};
                  state_d = EMIT2;
               end
            end
         end
         EMIT2: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_li_expander.sv
// Scoreboard bench: one instance with addiu enabled, one with it disabled.
module tb_li_expander;
   import li_expander_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        out_ready = 1'b1;
   logic [31:0] in_value = '0;
   logic [4:0]  in_rt = '0;
   logic        vld [2];
   logic        rdy [2];
   logic        ov  [2];
   logic [31:0] oi  [2];
   logic [1:0]  oe  [2];
   logic        ol  [2];

   word_t sb0[$];
   word_t sb1[$];
   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   li_expander #(.USE_ADDIU(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_ready(rdy[0]),
      .in_value(in_value), .in_rt(in_rt), .out_valid(ov[0]), .out_ready(out_ready),
      .out_instr(oi[0]), .out_eop(oe[0]), .out_last(ol[0])
   );

   li_expander #(.USE_ADDIU(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_ready(rdy[1]),
      .in_value(in_value), .in_rt(in_rt), .out_valid(ov[1]), .out_ready(out_ready),
      .out_instr(oi[1]), .out_eop(oe[1]), .out_last(ol[1])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic cmp_word(input int k, input word_t e);
      chk($sformatf("instr%0d", k), oi[k], e.instr);
      chk($sformatf("eop%0d", k), {30'd0, oe[k]}, {30'd0, e.eop});
      chk($sformatf("last%0d", k), {31'd0, ol[k]}, {31'd0, e.last});
      chk($sformatf("busy_in_ready%0d", k), {31'd0, rdy[k]}, 32'd0);
   endtask

   task automatic unexpected(input int k);
      n_vec++;
      n_err++;
      $display("FAIL extra_word%0d: got %h want none", k, oi[k]);
   endtask

   // Monitor: every valid cycle is checked against the queue head (covers hold-under-stall).
   always @(negedge clk) begin
      if (rst_n) begin
         if (ov[0]) begin
            if (sb0.size() == 0) unexpected(0);
            else begin
               cmp_word(0, sb0[0]);
               if (out_ready) void'(sb0.pop_front());
            end
         end
         if (ov[1]) begin
            if (sb1.size() == 0) unexpected(1);
            else begin
               cmp_word(1, sb1[0]);
               if (out_ready) void'(sb1.pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expw(input int k, input logic [31:0] i, input logic [1:0] e, input logic l);
      if (k == 0) sb0.push_back({i, e, l});
      else        sb1.push_back({i, e, l});
   endtask

   task automatic send(input int k, input logic [31:0] v, input logic [4:0] rt, input bit drop);
      int n = 0;
      in_value = v;
      in_rt    = rt;
      vld[k]   = 1'b1;
      while (!rdy[k] && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) chk("accept_timeout", 32'd0, 32'd1);
      tick();
      vld[k] = 1'b0;
      chk($sformatf("latency_valid%0d", k), {31'd0, ov[k]}, {31'd0, !drop});
   endtask

   task automatic drain();
      int n = 0;
      while ((sb0.size() != 0 || sb1.size() != 0 || ov[0] || ov[1]) && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) chk("drain_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      vld[0] = 1'b0;
      vld[1] = 1'b0;
      #12;
      chk("rst_valid", {31'd0, ov[0]}, 32'd0);
      chk("rst_ready", {31'd0, rdy[0]}, 32'd1);
      chk("rst_instr", oi[0], 32'd0);
      chk("rst_eop_last", {29'd0, oe[0], ol[0]}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      expw(0, 32'h24080005, EOP_SIGN, 1'b1); send(0, 32'h00000005, 5'd8, 1'b0); drain();
      expw(0, 32'h24088000, EOP_SIGN, 1'b1); send(0, 32'hFFFF8000, 5'd8, 1'b0); drain();
      expw(0, 32'h34088000, EOP_ZERO, 1'b1); send(0, 32'h00008000, 5'd8, 1'b0); drain();
      expw(0, 32'h3C081234, EOP_LUI,  1'b1); send(0, 32'h12340000, 5'd8, 1'b0); drain();
      expw(0, 32'h24080000, EOP_SIGN, 1'b1); send(0, 32'h00000000, 5'd8, 1'b0); drain();
      expw(0, 32'h241F0005, EOP_SIGN, 1'b1); send(0, 32'h00000005, 5'd31, 1'b0); drain();

      expw(1, 32'h3C08FFFF, EOP_LUI,  1'b0); expw(1, 32'h35088000, EOP_ZERO, 1'b1);
      send(1, 32'hFFFF8000, 5'd8, 1'b0); drain();
      expw(1, 32'h3C08FFFF, EOP_LUI,  1'b0); expw(1, 32'h3508FFFF, EOP_ZERO, 1'b1);
      send(1, 32'hFFFFFFFF, 5'd8, 1'b0); drain();
      expw(1, 32'h34080000, EOP_ZERO, 1'b1); send(1, 32'h00000000, 5'd8, 1'b0); drain();
      expw(1, 32'h34081234, EOP_ZERO, 1'b1); send(1, 32'h00001234, 5'd8, 1'b0); drain();

      // pair with backpressure on the first word
      out_ready = 1'b0;
      expw(0, 32'h3C081234, EOP_LUI,  1'b0); expw(0, 32'h35085678, EOP_ZERO, 1'b1);
      send(0, 32'h12345678, 5'd8, 1'b0);
      tick(); tick(); tick();
      out_ready = 1'b1;
      tick();
      chk("emit2_in_ready", {31'd0, rdy[0]}, 32'd0);
      chk("emit2_last", {31'd0, ol[0]}, 32'd1);
      drain();
      chk("pair_done_ready", {31'd0, rdy[0]}, 32'd1);

      // reset while the second word is pending
      expw(0, 32'h3C081234, EOP_LUI,  1'b0);
      send(0, 32'h12345678, 5'd8, 1'b0);
      tick();
      out_ready = 1'b0;
      chk("pre_reset_emit2", {31'd0, ol[0]}, 32'd1);
      rst_n = 1'b0;
      sb0.delete();
      #1;
      chk("midrst_valid", {31'd0, ov[0]}, 32'd0);
      chk("midrst_ready", {31'd0, rdy[0]}, 32'd1);
      tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      tick();
      chk("postrst_valid", {31'd0, ov[0]}, 32'd0);
      chk("postrst_ready", {31'd0, rdy[0]}, 32'd1);
      expw(0, 32'h24080005, EOP_SIGN, 1'b1); send(0, 32'h00000005, 5'd8, 1'b0); drain();

`ifdef LI_EXPANDER_ZERO_DROP_EN
      send(0, 32'h12345678, 5'd0, 1'b1);
      chk("drop_ready", {31'd0, rdy[0]}, 32'd1);
      tick(); tick();
      chk("drop_no_word", {31'd0, ov[0]}, 32'd0);
`else
      expw(0, 32'h3C001234, EOP_LUI,  1'b0); expw(0, 32'h34005678, EOP_ZERO, 1'b1);
      send(0, 32'h12345678, 5'd0, 1'b0); drain();
`endif
      tick(); tick();
      chk("final_idle", {30'd0, ov[0], ov[1]}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
